// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, total computation and RGB type.
// The pixel generator imports this package too.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  typedef logic [11:0]      rgb12_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing generator, the pixel generator and the VGA connector.
// master = timing generator, slave = consumer (pixel generator / connector side).
interface vga_timing_gen_if;
  import vga_pkg::*;

  rgb12_t     pixel_in;
  cnt_t       h_cnt;
  cnt_t       v_cnt;
  logic       valid;
  logic       pclk_en;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport master (
    input  pixel_in,
    output h_cnt, v_cnt, valid, pclk_en, frame_start,
    output hsync, vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output pixel_in,
    input  h_cnt, v_cnt, valid, pclk_en, frame_start,
    input  hsync, vsync, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/pixel_clk_en.sv
// Divides the system clock by CLK_DIV into a one-clk pixel strobe.
module pixel_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pclk_en
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Strobe is a decode of the divider, so it is low during reset (CLK_DIV >= 2).
  assign pclk_en = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters, sync decode and blanked RGB to the connector.
// Define VGA_PIPE_ALIGN_EN to register syncs/RGB one pixel behind the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || CLK_DIV < 2) begin : g_bad_cfg
      $error("vga_timing_gen: totals must be <= %0d and CLK_DIV >= 2", MAX_TOTAL);
    end
  endgenerate

  logic   pclk_en;
  cnt_t   h_cnt_reg;
  cnt_t   v_cnt_reg;
  logic   h_last;
  logic   v_last;
  logic   valid_c;
  logic   hsync_c;
  logic   vsync_c;
  rgb12_t rgb_c;
  logic   hsync_out;
  logic   vsync_out;
  rgb12_t rgb_out;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .clk     (clk),
    .rst     (rst),
    .pclk_en (pclk_en)
  );

  assign h_last = (h_cnt_reg == cnt_t'(H_TOTAL - 1));
  assign v_last = (v_cnt_reg == cnt_t'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pclk_en) begin
      if (h_last) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end
    end
  end

  // Comparisons are done one bit wider so a sync window ending at 1024 still decodes.
  assign valid_c = ({1'b0, h_cnt_reg} < (CNT_W+1)'(H_ACTIVE)) &&
                   ({1'b0, v_cnt_reg} < (CNT_W+1)'(V_ACTIVE));
  assign hsync_c = (({1'b0, h_cnt_reg} >= (CNT_W+1)'(HS_START)) &&
                    ({1'b0, h_cnt_reg} <  (CNT_W+1)'(HS_END))) ? SYNC_POL : ~SYNC_POL;
  assign vsync_c = (({1'b0, v_cnt_reg} >= (CNT_W+1)'(VS_START)) &&
                    ({1'b0, v_cnt_reg} <  (CNT_W+1)'(VS_END))) ? SYNC_POL : ~SYNC_POL;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_blank
      assign rgb_c[gi*4 +: 4] = valid_c ? bus.pixel_in[gi*4 +: 4] : 4'h0;
    end
  endgenerate

`ifdef VGA_PIPE_ALIGN_EN
  logic   hsync_reg;
  logic   vsync_reg;
  rgb12_t rgb_reg;

  // One pclk_en-enabled stage for syncs and colour keeps the connector outputs aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
      rgb_reg   <= '0;
    end else if (pclk_en) begin
      hsync_reg <= hsync_c;
      vsync_reg <= vsync_c;
      rgb_reg   <= rgb_c;
    end
  end

  assign hsync_out = hsync_reg;
  assign vsync_out = vsync_reg;
  assign rgb_out   = rgb_reg;
`else
  assign hsync_out = hsync_c;
  assign vsync_out = vsync_c;
  assign rgb_out   = rgb_c;
`endif

  assign bus.h_cnt       = h_cnt_reg;
  assign bus.v_cnt       = v_cnt_reg;
  assign bus.valid       = valid_c;
  assign bus.pclk_en     = pclk_en;
  assign bus.frame_start = pclk_en && h_last && v_last;
  assign bus.hsync       = hsync_out;
  assign bus.vsync       = vsync_out;
  assign bus.vga_r       = rgb_out[11:8];
  assign bus.vga_g       = rgb_out[7:4];
  assign bus.vga_b       = rgb_out[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (15x11) at CLK_DIV 4 and 2.
// Expected outputs come from a closed-form model of clocks elapsed since reset release.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int D1 = 4, D2 = 2;
  localparam logic POL = 1'b0;
`ifdef VGA_PIPE_ALIGN_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        valid;
    logic        pen;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if bus1();
  vga_timing_gen_if bus2();

  vga_timing_gen #(
    .CLK_DIV(D1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  vga_timing_gen #(
    .CLK_DIV(D2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  obs_t act1, act2;
  assign act1 = {bus1.h_cnt, bus1.v_cnt, bus1.valid, bus1.pclk_en, bus1.frame_start,
                 bus1.hsync, bus1.vsync, bus1.vga_r, bus1.vga_g, bus1.vga_b};
  assign act2 = {bus2.h_cnt, bus2.v_cnt, bus2.valid, bus2.pclk_en, bus2.frame_start,
                 bus2.hsync, bus2.vsync, bus2.vga_r, bus2.vga_g, bus2.vga_b};

  int   k;
  int   n_cmp;
  int   n_bad;
  obs_t sb1[$];
  obs_t sb2[$];

  function automatic logic [11:0] pat(input logic [9:0] h, input logic [9:0] v);
    logic [3:0] hh, vv;
    hh = h[3:0];
    vv = v[3:0];
    return {hh ^ 4'h5, vv ^ 4'hA, hh + vv};
  endfunction

  // Outputs after k clock edges out of reset, for pixel period dv.
  function automatic obs_t model(input int kk, input int dv);
    obs_t o;
    int p, h, v, dh, dvv;
    p = kk / dv;
    h = p % HT;
    v = (p / HT) % VT;
    o.h     = 10'(h);
    o.v     = 10'(v);
    o.valid = (h < HA) && (v < VA);
    o.pen   = (kk % dv) == dv - 1;
    o.fs    = o.pen && (h == HT - 1) && (v == VT - 1);
    if (PIPE && p == 0) begin
      o.hs  = ~POL;
      o.vs  = ~POL;
      o.rgb = 12'h000;
    end else begin
      dh  = PIPE ? (p - 1) % HT : h;
      dvv = PIPE ? ((p - 1) / HT) % VT : v;
      o.hs  = (dh >= HA + HF && dh < HA + HF + HS) ? POL : ~POL;
      o.vs  = (dvv >= VA + VF && dvv < VA + VF + VS) ? POL : ~POL;
      o.rgb = (dh < HA && dvv < VA) ? pat(10'(dh), 10'(dvv)) : 12'h000;
    end
    return o;
  endfunction

  task automatic drive_pixels();
    obs_t m1, m2;
    m1 = model(k, D1);
    m2 = model(k, D2);
    bus1.pixel_in = pat(m1.h, m1.v);
    bus2.pixel_in = pat(m2.h, m2.v);
  endtask

  // One clock: expected values are queued as the pixel is driven, then drained at negedge.
  task automatic step();
    obs_t e1, e2;
    @(posedge clk);
    #1;
    if (!rst) k++;
    drive_pixels();
    sb1.push_back(model(k, D1));
    sb2.push_back(model(k, D2));
    @(negedge clk);
    e1 = sb1.pop_front();
    e2 = sb2.pop_front();
    n_cmp++;
    if (act1 !== e1) begin
      n_bad++;
      $display("FAIL sb_div4 k=%0d got %h required %h", k, act1, e1);
    end
    n_cmp++;
    if (act2 !== e2) begin
      n_bad++;
      $display("FAIL sb_div2 k=%0d got %h required %h", k, act2, e2);
    end
  endtask

  task automatic check_release_timing(input string tag);
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++;
      if (act1.pen !== ((i % 4) == 3)) begin
        n_bad++;
        $display("FAIL %s_pclk_en cycle=%0d got %b required %b", tag, i, act1.pen, (i % 4) == 3);
      end
      if (i == 4) begin
        n_cmp++;
        if (act1.h !== 10'd1 || act1.v !== 10'd0) begin
          n_bad++;
          $display("FAIL %s_first_pixel got (%0d,%0d) required (1,0)", tag, act1.h, act1.v);
        end
      end
    end
  endtask

  task automatic test_reset();
    k = 0;
    drive_pixels();
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    n_cmp++;
    if (act1.h !== 10'd0 || act1.v !== 10'd0 || act1.pen !== 1'b0 || act1.hs !== ~POL) begin
      n_bad++;
      $display("FAIL reset_state got %h", act1);
    end
    rst = 1'b0;
    check_release_timing("release");
    $display("test_reset: release timing checked at k=%0d", k);
  endtask

  task automatic test_line_wrap();
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(act1.h == HT - 1 && act1.v == 2 && act1.pen) && guard < 2000);
    n_cmp++;
    if (!(act1.h == HT - 1 && act1.v == 2 && act1.pen)) begin
      n_bad++;
      $display("FAIL line_wrap_timeout got (%0d,%0d) required (%0d,2)", act1.h, act1.v, HT - 1);
    end
    step();
    n_cmp++;
    if (act1.h !== 10'd0 || act1.v !== 10'd3) begin
      n_bad++;
      $display("FAIL line_wrap got (%0d,%0d) required (0,3)", act1.h, act1.v);
    end
    $display("test_line_wrap: wrapped to line %0d", act1.v);
  endtask

  task automatic test_frame();
    int guard = 0;
    int c, f2a, f2b, hs_low, vs_low;
    do begin
      step();
      guard++;
    end while (act1.fs !== 1'b1 && guard < 2000);
    n_cmp++;
    if (act1.fs !== 1'b1 || act1.h !== 10'(HT - 1) || act1.v !== 10'(VT - 1)) begin
      n_bad++;
      $display("FAIL frame_start_pos got fs=%b (%0d,%0d) required fs=1 (%0d,%0d)",
               act1.fs, act1.h, act1.v, HT - 1, VT - 1);
    end
    step();
    n_cmp++;
    if (act1.fs !== 1'b0 || act1.h !== 10'd0 || act1.v !== 10'd0) begin
      n_bad++;
      $display("FAIL frame_wrap got fs=%b (%0d,%0d) required fs=0 (0,0)", act1.fs, act1.h, act1.v);
    end
    c = 1; f2a = -1; f2b = -1;
    hs_low = (act1.hs == POL) ? 1 : 0;
    vs_low = (act1.vs == POL) ? 1 : 0;
    while (guard < 4000) begin
      step();
      guard++;
      c++;
      if (act1.hs == POL) hs_low++;
      if (act1.vs == POL) vs_low++;
      if (act2.fs === 1'b1) begin
        f2a = f2b;
        f2b = c;
      end
      if (act1.fs === 1'b1) break;
    end
    n_cmp++;
    if (c != HT * VT * D1) begin
      n_bad++;
      $display("FAIL frame_period_div4 got %0d required %0d", c, HT * VT * D1);
    end
    n_cmp++;
    if (f2b - f2a != HT * VT * D2 || f2a < 0) begin
      n_bad++;
      $display("FAIL frame_period_div2 got %0d required %0d", f2b - f2a, HT * VT * D2);
    end
    n_cmp++;
    if (hs_low != VT * HS * D1) begin
      n_bad++;
      $display("FAIL hsync_low_clocks got %0d required %0d", hs_low, VT * HS * D1);
    end
    n_cmp++;
    if (vs_low != VS * HT * D1) begin
      n_bad++;
      $display("FAIL vsync_low_clocks got %0d required %0d", vs_low, VS * HT * D1);
    end
    $display("test_frame: period %0d clocks, hsync low %0d, vsync low %0d", c, hs_low, vs_low);
  endtask

  task automatic test_blanking();
    int   violations = 0;
    int   guard = 0;
    logic lag_valid;
    do begin
      step();
      guard++;
    end while (act1.pen !== 1'b1 && guard < 10);
    lag_valid = act1.valid;
    for (int i = 0; i < HT * VT * D1; i++) begin
      step();
      if (act1.rgb != 12'h000 && !(PIPE ? lag_valid : act1.valid)) violations++;
      if (act1.pen) lag_valid = act1.valid;
    end
    n_cmp++;
    if (violations != 0) begin
      n_bad++;
      $display("FAIL blanking got %0d non-black blank clocks required 0", violations);
    end
    $display("test_blanking: one frame scanned, %0d blank violations", violations);
  endtask

  task automatic test_async_reset();
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(act1.h == 5 && act1.v == 3 && !act1.pen) && guard < 2000);
    n_cmp++;
    if (!(act1.h == 5 && act1.v == 3)) begin
      n_bad++;
      $display("FAIL async_reset_timeout got (%0d,%0d) required (5,3)", act1.h, act1.v);
    end
    #2;
    rst = 1'b1;
    k = 0;
    drive_pixels();
    #1;
    n_cmp++;
    if (act1 !== model(0, D1)) begin
      n_bad++;
      $display("FAIL async_reset_div4 got %h required %h", act1, model(0, D1));
    end
    n_cmp++;
    if (act2 !== model(0, D2)) begin
      n_bad++;
      $display("FAIL async_reset_div2 got %h required %h", act2, model(0, D2));
    end
    step();
    step();
    rst = 1'b0;
    check_release_timing("rerelease");
    $display("test_async_reset: counters cleared mid-pixel, restart checked");
  endtask

  task automatic test_div2();
    logic prev;
    step();
    prev = act2.pen;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (act2.pen !== ~prev) begin
        n_bad++;
        $display("FAIL div2_strobe got %b required %b", act2.pen, ~prev);
      end
      prev = act2.pen;
    end
    $display("test_div2: strobe alternates every clock");
  endtask

  initial begin
    k = 0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_line_wrap();
    test_frame();
    test_blanking();
    test_async_reset();
    test_div2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 VGA raster timing from the system clock and drives the VGA connector. It produces the `h_cnt`/`v_cnt` scan coordinates consumed by the pixel generator and takes back that block's 12-bit `pixel` word. From these it drives `hsync`, `vsync` and the 4:4:4 RGB outputs, with RGB forced to black during blanking. It sits between the top level and the pixel generator, replacing any free-running sync logic.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be ≥ 2.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `SYNC_POL`, 0: asserted sync level (0 = active-low).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `pixel_in` in 12: `{R,G,B}` from the pixel generator for the current `h_cnt`/`v_cnt`.
- `h_cnt` out 10: current pixel column, 0..H_TOTAL-1.
- `v_cnt` out 10: current line, 0..V_TOTAL-1.
- `valid` out 1: current coordinate is in the active area.
- `pclk_en` out 1: one-`clk` pixel strobe.
- `frame_start` out 1: one-`clk` pulse at frame wrap.
- `hsync` out 1: horizontal sync to the connector.
- `vsync` out 1: vertical sync to the connector.
- `vga_r` out 4: red to the connector.
- `vga_g` out 4: green to the connector.
- `vga_b` out 4: blue to the connector.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; elaboration fails otherwise.
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. `pclk_en` = (`div` == CLK_DIV-1).
- On a `clk` edge with `pclk_en` high:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At V_TOTAL-1 together with the `h_cnt` wrap, `v_cnt` wraps to 0.
- Counters hold when `pclk_en` is low.
- `valid` = `h_cnt` < H_ACTIVE && `v_cnt` < V_ACTIVE (combinational decode of the counters).
- hsync is asserted (= SYNC_POL) for H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751. vsync is asserted for 490..491, using the same formula on `v_cnt`. Both are at ~SYNC_POL otherwise.
- `frame_start` = `pclk_en` && `h_cnt`==H_TOTAL-1 && `v_cnt`==V_TOTAL-1.
- RGB = `pixel_in` when the pixel is valid, else 12'h000. RGB is never driven non-zero while `valid` (or its delayed copy) is low.
- Async reset: `div`, `h_cnt`, `v_cnt` go to 0 immediately, with no clock edge needed. `pclk_en` and `frame_start` go to 0. Registered sync outputs go inactive and registered RGB goes to 0. Asserting reset mid-frame aborts the frame; the first frame after release starts at (0,0).

## Timing
- Reset release: the first `pclk_en` occurs on the CLK_DIV-th `clk` cycle after `rst` falls. `h_cnt` becomes 1 on that edge.
- Each coordinate is held for CLK_DIV `clk` cycles. The pixel generator's 1-cycle BRAM read therefore settles before the next `pclk_en`.
- Line period is H_TOTAL·CLK_DIV clocks (3200). Frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks (1,680,000).

## Configuration
- `VGA_PIPE_ALIGN_EN` defined:
  - RGB is registered from (`valid` ? `pixel_in` : 0) on `pclk_en`.
  - `hsync`/`vsync` pass through one matching `pclk_en`-enabled register.
  - All connector outputs lag `h_cnt`/`v_cnt` by exactly one pixel and stay mutually aligned. The outputs are glitch-free.
  - Reset values: syncs inactive, RGB 0.
- Undefined:
  - `hsync`/`vsync`/RGB are combinational decodes of the current counters and `pixel_in`, with zero pixel lag.
  - At reset they read syncs inactive and RGB = `pixel_in` (since (0,0) is valid).

## Structure
- Shared package `vga_pkg`: default timing constants, the H_TOTAL/V_TOTAL computation, and the 12-bit RGB typedef `rgb12_t`. The pixel generator reuses this package.
- One sub-module, `pixel_clk_en`: the CLK_DIV divider producing `pclk_en`, with async active-high reset.

## Test plan
- Release `rst` with CLK_DIV=4 -> `pclk_en` high in the 4th `clk` cycle after release, then every 4 cycles. `h_cnt`=1, `v_cnt`=0 after the first strobe.
- Run to `h_cnt`=799, `v_cnt`=10 -> the next `pclk_en` gives `h_cnt`=0, `v_cnt`=11. At `h_cnt`=799, `v_cnt`=524 -> (0,0) and a `frame_start` pulse one `clk` wide. Consecutive `frame_start` pulses are 1,680,000 clocks apart.
- Measure syncs -> `hsync` is low for 96 pixels (`h_cnt` 656..751) every line. `vsync` is low for exactly lines 490..491 (6400 clocks). With `VGA_PIPE_ALIGN_EN`, both edges lag by 4 clocks.
- Drive `pixel_in`=12'hABC -> at `h_cnt`=639, `v_cnt`=100 RGB = A/B/C. At `h_cnt`=640, or at any `v_cnt` ≥ 480, RGB = 0/0/0. With `VGA_PIPE_ALIGN_EN` each transition occurs one pixel later.
- Assert `rst` asynchronously at `h_cnt`=300, `v_cnt`=200, mid-pixel -> counters read 0 before the next `clk` edge and `pclk_en`=0. After release, timing matches scenario 1.
- Build with CLK_DIV=2 -> `pclk_en` is high every other clock and the frame period is 840,000 clocks.
